// File: rtl/hacc_array.sv
// Windowed unary popcount accumulator: IDIM channels summed over 2**BSLW beats.
// Define HACC_PIPE_EN to register popcounts before the adders (adds a DRAIN state).
module hacc_array #(
  parameter int unsigned IDIM = 4,
  parameter int unsigned ADIM = 32,
  parameter int unsigned BSLW = 8,
  parameter int unsigned OWID = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iStart,
  input  logic [ADIM-1:0] iBit [IDIM],
  input  logic            iValid,
  output logic            oReady,
  output logic [OWID-1:0] oData [IDIM],
  output logic            oValid,
  input  logic            iReady,
  output logic            oBusy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC
`ifdef HACC_PIPE_EN
    , S_DRAIN
`endif
  } state_t;

  state_t          state, state_nxt;
  logic [BSLW-1:0] cnt;
  logic [OWID-1:0] acc  [IDIM];
  logic [OWID-1:0] pop  [IDIM];
  logic [OWID-1:0] sum  [IDIM];
  logic            last_cnt, accept, last_beat, clear, load;

`ifdef HACC_PIPE_EN
  logic [OWID-1:0] pop_r [IDIM];
  logic            pop_v;
`endif

  function automatic logic [OWID-1:0] popcnt(input logic [ADIM-1:0] v);
    logic [OWID-1:0] s;
    s = '0;
    for (int unsigned k = 0; k < ADIM; k++) s = s + OWID'(v[k]);
    return s;
  endfunction

  always_comb begin
    for (int unsigned c = 0; c < IDIM; c++) begin
      pop[c] = popcnt(iBit[c]);
`ifdef HACC_PIPE_EN
      sum[c] = acc[c] + pop_r[c];
`else
      sum[c] = acc[c] + pop[c];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // The last beat is held off only while an unconsumed result would be overwritten.
  always_comb begin
    state_nxt = state;
    last_cnt  = (cnt == '1);
    oReady    = (state == S_ACC) && !(last_cnt && oValid && !iReady);
    accept    = iValid && oReady;
    last_beat = accept && last_cnt;
    clear     = (state == S_IDLE) && iStart;
    oBusy     = (state != S_IDLE);
    load      = 1'b0;
    unique case (state)
      S_IDLE: if (iStart) state_nxt = S_ACC;
      S_ACC: begin
        if (last_beat) begin
`ifdef HACC_PIPE_EN
          state_nxt = S_DRAIN;
`else
          state_nxt = S_IDLE;
          load      = 1'b1;
`endif
        end
      end
`ifdef HACC_PIPE_EN
      S_DRAIN: begin
        state_nxt = S_IDLE;
        load      = 1'b1;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      oValid <= 1'b0;
      for (int unsigned c = 0; c < IDIM; c++) begin
        acc[c]   <= '0;
        oData[c] <= '0;
`ifdef HACC_PIPE_EN
        pop_r[c] <= '0;
`endif
      end
`ifdef HACC_PIPE_EN
      pop_v <= 1'b0;
`endif
    end else begin
`ifdef HACC_PIPE_EN
      // Popcounts land one cycle late; the final one is folded in by DRAIN's load.
      pop_v <= accept;
      for (int unsigned c = 0; c < IDIM; c++) begin
        if (accept) pop_r[c] <= pop[c];
        if (clear)      acc[c] <= '0;
        else if (pop_v) acc[c] <= sum[c];
      end
`else
      for (int unsigned c = 0; c < IDIM; c++) begin
        if (clear)       acc[c] <= '0;
        else if (accept) acc[c] <= sum[c];
      end
`endif
      if (clear)       cnt <= '0;
      else if (accept) cnt <= cnt + BSLW'(1);

      for (int unsigned c = 0; c < IDIM; c++)
        if (load) oData[c] <= sum[c];

      if (load)                  oValid <= 1'b1;
      else if (oValid && iReady) oValid <= 1'b0;
    end
  end

endmodule

// File: doc/hacc_array.md
HACC_ARRAY -- requirements
Module: hacc_array

Interface
REQ-001 SHALL have parameter IDIM, default 4: number of output channels.
REQ-002 SHALL have parameter ADIM, default 32: unary bits per channel per beat.
REQ-003 SHALL have parameter BSLW, default 8: log2 of the window length; one window is 2**BSLW beats.
REQ-004 SHALL have parameter OWID, default 16: count width, constrained so that OWID >= clog2(ADIM*2**BSLW + 1).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port iStart, input, 1 bit: starts one accumulation window.
REQ-008 SHALL have port iBit, input, [ADIM-1:0] x [IDIM-1:0] unpacked: unary bits for each channel.
REQ-009 SHALL have port iValid, input, 1 bit: iBit carries a beat this cycle.
REQ-010 SHALL have port oReady, output, 1 bit: the block accepts a beat this cycle.
REQ-011 SHALL have port oData, output, [OWID-1:0] x [IDIM-1:0] unpacked: offset-binary window counts; ADIM*2**BSLW/2 is the zero point.
REQ-012 SHALL have port oValid, output, 1 bit: oData holds an unconsumed result.
REQ-013 SHALL have port iReady, input, 1 bit: the downstream consumer takes oData.
REQ-014 SHALL have port oBusy, output, 1 bit: high in any state other than IDLE.

Function
REQ-015 SHALL implement the states IDLE, ACC and DRAIN; DRAIN is used only when HACC_PIPE_EN is defined.
REQ-016 SHALL move IDLE->ACC on iStart=1 and, in that same cycle, clear all accumulators and the beat counter; iStart SHALL be ignored in ACC and DRAIN.
REQ-017 SHALL count a beat as accepted when iValid=1 and oReady=1; only accepted beats SHALL update the accumulators or the beat counter.
REQ-018 SHALL add popcount(iBit[i]) into accumulator i for each accepted beat, with no wrap and no saturation (guaranteed by REQ-004).
REQ-019 SHALL define the last beat as the accepted beat with beat counter = 2**BSLW-1.
REQ-020 SHALL drive oReady = (state==ACC) AND NOT(beat counter==2**BSLW-1 AND oValid==1 AND iReady==0); this stalls the last beat while an unconsumed result is held.
REQ-021 SHALL, without HACC_PIPE_EN, on the cycle after the last beat: load oData with the final sums, set oValid=1, and go to IDLE.
REQ-022 SHALL complete the output handshake when oValid=1 and iReady=1, clearing oValid on the next cycle unless a new result loads in that same cycle, in which case oValid SHALL stay 1 with the new data.
REQ-023 SHALL hold oData stable while oValid=1 and iReady=0.
REQ-024 SHALL allow a new window to start from IDLE while oValid=1; that window SHALL stall only at its last beat (REQ-020).

Reset
REQ-025 SHALL, while rst_n=0 (asynchronously), force state=IDLE, all accumulators=0, beat counter=0, oData=0, oValid=0, oReady=0 and oBusy=0.
REQ-026 SHALL discard any partial window interrupted by reset; accumulation SHALL resume only on a new iStart.

Configuration
REQ-027 SHALL, when macro HACC_PIPE_EN is defined, register the popcounts before the adders: each accepted beat adds into its accumulator one cycle later, the last beat leads to DRAIN, and DRAIN loads oData/oValid and returns to IDLE, so oValid rises 2 cycles after the last beat.
REQ-028 SHALL, when HACC_PIPE_EN is undefined, have no popcount register and no DRAIN state, so oValid rises 1 cycle after the last beat.

Verification
REQ-029 SHALL cover: defaults, all iBit=1, iValid=1, iReady=1 for 256 beats -> oData[i]=8192 for every i, oValid one cycle after the last beat (two cycles with HACC_PIPE_EN).
REQ-030 SHALL cover: all iBit=0 for 256 beats -> oData[i]=0 and oValid=1.
REQ-031 SHALL cover: channel 0 with 16 ones per beat, channel 3 with 17 ones per beat -> oData[0]=4096 (zero point), oData[3]=4352.
REQ-032 SHALL cover: iValid deasserted on 100 random cycles inside one window -> results identical to REQ-029, and oValid rises only after the 256th accepted beat.
REQ-033 SHALL cover: iReady=0, two back-to-back windows -> the first result is held stable, the second window stalls with oReady=0 at beat 255, and one iReady pulse accepts the last beat and loads the second result with oValid staying 1.
REQ-034 SHALL cover: rst_n pulsed low at accepted beat 100 -> all outputs 0 immediately; a later iStart followed by 256 all-ones beats yields 8192, with no carry-over from the interrupted window.
